mix_columns_seq: RTL and testbench
==================================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous active-high reset.
REQ-003 The block SHALL have the port in, input, 128 bits: AES state; byte s(r,c) = in[127-8*(4c+r) -: 8], column c = in[127-32c -: 32].
REQ-004 The block SHALL have the port in_valid, input, 1 bit: in is valid.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block accepts in this cycle.
REQ-006 The block SHALL have the port out, output, 128 bits: MixColumns result, same byte ordering as in.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: out holds a completed result.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: the consumer takes out this cycle.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-010 A transfer SHALL occur on a rising edge where in_valid && in_ready; the block SHALL latch in into an internal 128-bit state register and clear the 2-bit column counter col.
REQ-011 The FSM SHALL go IDLE->BUSY on an accepted transfer and SHALL otherwise hold IDLE.
REQ-012 In BUSY, each cycle SHALL replace column col with its MixColumns product and increment col, processing columns 0,1,2,3 in order, one column per cycle.
REQ-013 The per-column product SHALL be s'0=2a0^3a1^a2^a3, s'1=a0^2a1^3a2^a3, s'2=a0^a1^2a2^3a3, s'3=3a0^a1^a2^2a3, computed in GF(2^8) with xtime reduction by 0x1B and 8-bit truncation.
REQ-014 The FSM SHALL go BUSY->DONE on the edge that writes column 3, with col wrapping to 0.
REQ-015 Latency SHALL be fixed: if accepted at edge k, out_valid SHALL rise after edge k+4.
REQ-016 In DONE, out_valid SHALL be 1 and out SHALL be stable until a rising edge with out_ready=1.
REQ-017 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal to out_ready in DONE.
REQ-018 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE.
REQ-019 In DONE with out_ready=1 and in_valid=1, the block SHALL accept the new block on the same edge and go directly to BUSY, giving back-to-back throughput of one block per 5 cycles.
REQ-020 in_valid asserted in BUSY SHALL be ignored, with no effect on the state or the result.
REQ-021 out SHALL equal the internal state register at all times; only the value present while out_valid=1 is defined as a result.

Reset
REQ-022 With rst=1 at a rising edge, the block SHALL go to IDLE with col=0, state register=128'h0 (so out=0) and out_valid=0.
REQ-023 Reset SHALL take priority over any simultaneous transfer.
REQ-024 Reset asserted in BUSY or DONE SHALL discard the block in flight; no out_valid pulse follows.
REQ-025 in_ready SHALL be 1 in the first cycle after reset is deasserted.

Configuration
REQ-026 When macro MIX_COLUMNS_SEQ_INV_EN is defined, the block SHALL add the port inv (input, 1 bit), sampled at transfer.
REQ-027 When inv=1 is sampled at transfer, the block SHALL use the InvMixColumns coefficients {0e,0b,0d,09} for the whole block, with identical timing and handshake.
REQ-028 When the macro is not defined, the port inv SHALL be absent and the block SHALL implement forward MixColumns only, with no inverse multiplier logic.

Verification
REQ-029 in=6309518c63a7ca23f46363fc632d53ca with out_ready=1: out_valid SHALL rise 4 cycles after accept with out=000e47fedd502e8ec96b4ee42806ad54.
REQ-030 in=fee034fdded7f59cddd818fad371bb0c: out SHALL be 15846a2cacf3477830a4205399ebdbbc.
REQ-031 Hold out_ready=0 for 10 cycles after DONE: out_valid SHALL stay 1 with out unchanged, in_ready SHALL stay 0, and a pulse of in_valid SHALL not be accepted.
REQ-032 Back-to-back: with the second block offered while in DONE and out_ready=1, both results SHALL be correct and the two out_valid rising edges SHALL be exactly 5 cycles apart.
REQ-033 Assert rst during BUSY col=2: next cycle out=0, out_valid=0 and in_ready=1, and no stale result SHALL appear afterward.
REQ-034 With MIX_COLUMNS_SEQ_INV_EN defined and inv=1: in=000e47fedd502e8ec96b4ee42806ad54 SHALL give out=6309518c63a7ca23f46363fc632d53ca.

Source files
------------

// File: rtl/mix_columns_seq.v
`default_nettype none
// ============================================================================
// Module   : mix_columns_seq
// Brief    : Sequential AES MixColumns, one column per clock, valid/ready I/O.
//            Optional InvMixColumns selected per block when
//            MIX_COLUMNS_SEQ_INV_EN is defined (adds the inv input).
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef MIX_COLUMNS_SEQ_INV_EN
    input  logic         inv,
`endif
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_last_col = 2'd3;
    localparam logic [7:0] c_poly     = 8'h1b;

    state_t       r_fsm;
    logic [1:0]   r_col;
    logic [127:0] r_state;
    logic         r_out_valid;

    logic [31:0]  w_col;
    logic [7:0]   w_a0, w_a1, w_a2, w_a3;
    logic [31:0]  w_fwd;
    logic [31:0]  w_mixed;
    logic         w_accept;

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? c_poly : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        mul3 = xt(b) ^ b;
    endfunction

    // ------------------------------------------------------------------
    // Column select and forward product
    // ------------------------------------------------------------------
    always_comb begin
        w_col = r_state[127:96];
        case (r_col)
            2'd0:    w_col = r_state[127:96];
            2'd1:    w_col = r_state[95:64];
            2'd2:    w_col = r_state[63:32];
            default: w_col = r_state[31:0];
        endcase
    end

    assign w_a0 = w_col[31:24];
    assign w_a1 = w_col[23:16];
    assign w_a2 = w_col[15:8];
    assign w_a3 = w_col[7:0];

    assign w_fwd = {xt(w_a0) ^ mul3(w_a1) ^ w_a2       ^ w_a3,
                    w_a0     ^ xt(w_a1)   ^ mul3(w_a2) ^ w_a3,
                    w_a0     ^ w_a1       ^ xt(w_a2)   ^ mul3(w_a3),
                    mul3(w_a0) ^ w_a1     ^ w_a2       ^ xt(w_a3)};

`ifdef MIX_COLUMNS_SEQ_INV_EN
    logic        r_inv;
    logic [31:0] w_inv;

    // Inverse coefficients built from x2/x4/x8 multiples of each byte.
    function automatic logic [7:0] mul9(input logic [7:0] b);
        mul9 = xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        mulb = xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        muld = xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        mule = xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    assign w_inv = {mule(w_a0) ^ mulb(w_a1) ^ muld(w_a2) ^ mul9(w_a3),
                    mul9(w_a0) ^ mule(w_a1) ^ mulb(w_a2) ^ muld(w_a3),
                    muld(w_a0) ^ mul9(w_a1) ^ mule(w_a2) ^ mulb(w_a3),
                    mulb(w_a0) ^ muld(w_a1) ^ mul9(w_a2) ^ mule(w_a3)};

    assign w_mixed = r_inv ? w_inv : w_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv <= 1'b0;
        end else if (w_accept) begin
            r_inv <= inv;
        end
    end
`else
    assign w_mixed = w_fwd;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        case (r_fsm)
            S_IDLE:  in_ready = 1'b1;
            S_BUSY:  in_ready = 1'b0;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign w_accept  = in_valid && in_ready;
    assign out       = r_state;
    assign out_valid = r_out_valid;

    // ------------------------------------------------------------------
    // Control FSM and state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_col       <= 2'd0;
            r_state     <= 128'h0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= in;
                        r_col   <= 2'd0;
                        r_fsm   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    case (r_col)
                        2'd0:    r_state[127:96] <= w_mixed;
                        2'd1:    r_state[95:64]  <= w_mixed;
                        2'd2:    r_state[63:32]  <= w_mixed;
                        default: r_state[31:0]   <= w_mixed;
                    endcase
                    r_col <= r_col + 2'd1;
                    if (r_col == c_last_col) begin
                        r_fsm       <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Consumer handoff; a waiting block is taken on the same edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_state <= in;
                            r_col   <= 2'd0;
                            r_fsm   <= S_BUSY;
                        end else begin
                            r_fsm <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_col       <= 2'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_seq
// Brief    : Self-checking bench for mix_columns_seq (vectors, random, corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] dout;
    logic         out_valid;
    logic         out_ready;
`ifdef MIX_COLUMNS_SEQ_INV_EN
    logic         inv_s;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MIX_COLUMNS_SEQ_INV_EN
        .inv       (inv_s),
`endif
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: generic GF(2^8) multiply and circulant matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv_b);
        logic [7:0]   base [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv_b) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j - row + 4) % 4], a[j]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_inv(input bit v);
`ifdef MIX_COLUMNS_SEQ_INV_EN
        inv_s = v;
`else
        if (v) $display("note: inverse mode not built");
`endif
    endtask

    // Entered #1 after an edge with the DUT idle; leaves it idle again.
    task automatic run_block(input logic [127:0] d, input bit inv_b, input logic [127:0] exp,
                             input int stall, input string name);
        int n;
        din       = d;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        set_inv(inv_b);
        check({name, "_rdy"}, 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = rnd128();
        set_inv(~inv_b);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, 128'(n), 128'd4);
        check({name, "_out"}, dout, exp);
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            check({name, "_held"}, {dout[126:0], out_valid}, {exp[126:0], 1'b1});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_drain"}, 128'(out_valid), 128'd0);
    endtask

    typedef struct {
        logic [127:0] d;
        logic [127:0] e;
    } vec_t;

    vec_t tbl [3];

    initial begin
        logic [127:0] a_in, b_in, r;
        int           cyc, t1, t2, rises, hits;
        bit           prev, iv;

        tbl[0] = '{128'h6309518c63a7ca23f46363fc632d53ca, 128'h000e47fedd502e8ec96b4ee42806ad54};
        tbl[1] = '{128'hfee034fdded7f59cddd818fad371bb0c, 128'h15846a2cacf3477830a4205399ebdbbc};
        tbl[2] = '{128'hdb135345f20a225c01010101c6c6c6c6, 128'h8e4da1bc9fdc589d01010101c6c6c6c6};

        rst = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b0;
        set_inv(1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", dout, 128'h0);
        check("rst_valid", 128'(out_valid), 128'd0);
        rst = 1'b0;
        check("rst_ready", 128'(in_ready), 128'd1);

        // Known vectors
        for (int i = 0; i < 3; i++) run_block(tbl[i].d, 1'b0, tbl[i].e, i, $sformatf("vec%0d", i));

        // Random blocks against the model
        for (int i = 0; i < 16; i++) begin
            r = rnd128();
`ifdef MIX_COLUMNS_SEQ_INV_EN
            iv = bit'($urandom_range(0, 1));
`else
            iv = 1'b0;
`endif
            run_block(r, iv, ref_mix(r, iv), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

`ifdef MIX_COLUMNS_SEQ_INV_EN
        run_block(128'h000e47fedd502e8ec96b4ee42806ad54, 1'b1,
                  128'h6309518c63a7ca23f46363fc632d53ca, 0, "inv_vec");
        set_inv(1'b0);
`endif

        // Long stall in DONE with an in_valid pulse that must be ignored
        a_in = rnd128();
        din = a_in; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        hits = 0;
        while (!out_valid && hits < 20) begin @(posedge clk); #1; hits++; end
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            din      = rnd128();
            @(posedge clk); #1;
            check($sformatf("stall%0d", i), {dout, in_ready, out_valid},
                  {ref_mix(a_in, 1'b0), 1'b0, 1'b1});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall_exit", {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});
        hits = 0;
        repeat (6) begin @(posedge clk); #1; if (out_valid) hits++; end
        check("stall_no_accept", 128'(hits), 128'd0);

        // Back-to-back: second block waiting while the first is in DONE
        a_in = rnd128(); b_in = rnd128();
        din = a_in; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        din = b_in;
        cyc = 0; t1 = -1; t2 = -1; rises = 0; prev = 1'b0;
        while (rises < 2 && cyc < 30) begin
            if (out_valid && !prev) begin
                rises++;
                if (rises == 1) begin
                    t1 = cyc;
                    check("b2b_first", dout, ref_mix(a_in, 1'b0));
                end else begin
                    t2 = cyc;
                    check("b2b_second", dout, ref_mix(b_in, 1'b0));
                    in_valid = 1'b0;
                end
            end
            prev = out_valid;
            if (rises < 2) begin @(posedge clk); #1; cyc++; end
        end
        check("b2b_spacing", 128'(t2 - t1), 128'd5);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_idle", 128'(out_valid), 128'd0);

        // Reset while BUSY at column 2
        din = rnd128(); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst", {dout, in_ready, out_valid}, {128'h0, 1'b1, 1'b0});
        hits = 0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) hits++; end
        check("midrst_no_stale", 128'(hits), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
